bicubic_pixel_in_pad: RTL and testbench



---
 rtl/bicubic_pkg.sv | 18 +
 rtl/bicubic_pixel_in_pad.sv | 121 ++++++++++++
 tb/tb_bicubic_pixel_in_pad.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/bicubic_pkg.sv
// Shared types for the Bicubic pipeline: pixel width, pad FSM states and the
// two-pixel beat layout (lo = earlier/left pixel).
package bicubic_pkg;

  localparam int PIXEL_W = 16;

  typedef enum logic [1:0] {
    LINE_START,
    BODY,
    TAIL
  } pad_state_t;

  typedef struct packed {
    logic [PIXEL_W-1:0] hi;
    logic [PIXEL_W-1:0] lo;
  } pix_pair_t;

endpackage

// File: rtl/bicubic_pixel_in_pad.sv
// Input-side horizontal pad: shifts a two-pixel-per-beat stream by one pixel
// and appends a tail beat per line, so each line gains one border pixel on
// both sides. Build option BICUBIC_PAD_ZERO_EN selects zero padding instead
// of edge replication. One registered output stage, valid/ready both ways.
module bicubic_pixel_in_pad
  import bicubic_pkg::*;
(
  input  logic                 clk,
  input  logic                 sclr,
  input  logic                 clken,
  input  logic [2*PIXEL_W-1:0] pixel_in,
  input  logic                 pixel_valid_in,
  output logic                 pixel_ready_out,
  input  logic                 pixel_end_of_line_in,
  input  logic                 pixel_start_of_frame_in,
  output logic [2*PIXEL_W-1:0] pixel_pad_out,
  output logic                 pixel_valid_out,
  input  logic                 pixel_ready_in,
  output logic                 pixel_start_of_frame_out,
  output logic                 pixel_end_of_line_out
);

`ifdef BICUBIC_PAD_ZERO_EN
  localparam bit PAD_ZERO = 1'b1;
`else
  localparam bit PAD_ZERO = 1'b0;
`endif

  // Border pixel: either a copy of the edge pixel or black.
  function automatic logic [PIXEL_W-1:0] pad_px(input logic [PIXEL_W-1:0] px);
    return PAD_ZERO ? '0 : px;
  endfunction

  // Power-up values match the sclr state so the block is sane before the
  // first clear.
  pad_state_t         state = LINE_START;
  pad_state_t         nxt_state;
  logic [PIXEL_W-1:0] held  = '0;
  pix_pair_t          out_q = '0;
  logic               vld_q = 1'b0;
  logic               sof_q = 1'b0;
  logic               eol_q = 1'b0;

  pix_pair_t din, beat;
  logic      vld_n, sof_n, eol_n;
  logic      adv, slot_free, in_fire;

  assign din       = pixel_in;
  assign adv       = clken & ~sclr;
  // Output register may load when empty or drained this cycle.
  assign slot_free = ~vld_q | pixel_ready_in;

  assign pixel_ready_out = adv & (state != TAIL) & slot_free;
  assign in_fire         = pixel_valid_in & pixel_ready_out;

  // Next state and the beat to load into the output register.
  always_comb begin
    nxt_state = state;
    beat      = out_q;
    vld_n     = 1'b0;
    sof_n     = 1'b0;
    eol_n     = 1'b0;
    case (state)
      LINE_START, BODY: begin
        if (in_fire) begin
          vld_n     = 1'b1;
          sof_n     = pixel_start_of_frame_in;
          beat.hi   = din.lo;
          beat.lo   = (state == LINE_START) ? pad_px(din.lo) : held;
          nxt_state = pixel_end_of_line_in ? TAIL : BODY;
        end
      end
      TAIL: begin
        // Right border beat; input eol is never forwarded on data beats.
        if (adv & slot_free) begin
          vld_n     = 1'b1;
          eol_n     = 1'b1;
          beat.hi   = pad_px(held);
          beat.lo   = held;
          nxt_state = LINE_START;
        end
      end
      default: nxt_state = LINE_START;
    endcase
  end

  // FSM state register; a mid-line clear drops the partial line.
  always_ff @(posedge clk) begin
    if (clken) begin
      if (sclr) state <= LINE_START;
      else      state <= nxt_state;
    end
  end

  // Held pixel and output register; frozen while clken is low or output stalls.
  always_ff @(posedge clk) begin
    if (clken) begin
      if (sclr) begin
        held  <= '0;
        out_q <= '0;
        vld_q <= 1'b0;
        sof_q <= 1'b0;
        eol_q <= 1'b0;
      end else begin
        if (in_fire) held <= din.hi;
        if (slot_free) begin
          vld_q <= vld_n;
          sof_q <= sof_n;
          eol_q <= eol_n;
          if (vld_n) out_q <= beat;
        end
      end
    end
  end

  assign pixel_pad_out            = out_q;
  assign pixel_valid_out          = vld_q;
  assign pixel_start_of_frame_out = sof_q;
  assign pixel_end_of_line_out    = eol_q;

endmodule

// File: tb/tb_bicubic_pixel_in_pad.sv
// Directed bench for bicubic_pixel_in_pad. Inputs change on the falling edge,
// outputs are sampled shortly after it; a monitor collects output transfers.
module tb_bicubic_pixel_in_pad;

`ifdef BICUBIC_PAD_ZERO_EN
  localparam bit PZ = 1'b1;
`else
  localparam bit PZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        sclr, clken;
  logic [31:0] pixel_in;
  logic        pixel_valid_in, pixel_ready_out;
  logic        pixel_end_of_line_in, pixel_start_of_frame_in;
  logic [31:0] pixel_pad_out;
  logic        pixel_valid_out, pixel_ready_in;
  logic        pixel_start_of_frame_out, pixel_end_of_line_out;

  int n_chk  = 0;
  int n_pass = 0;
  logic [33:0] gotq[$];
  logic [33:0] exp1[$];
  logic [33:0] expq[$];
  bit tog_done;

  bicubic_pixel_in_pad dut (
    .clk                      (clk),
    .sclr                     (sclr),
    .clken                    (clken),
    .pixel_in                 (pixel_in),
    .pixel_valid_in           (pixel_valid_in),
    .pixel_ready_out          (pixel_ready_out),
    .pixel_end_of_line_in     (pixel_end_of_line_in),
    .pixel_start_of_frame_in  (pixel_start_of_frame_in),
    .pixel_pad_out            (pixel_pad_out),
    .pixel_valid_out          (pixel_valid_out),
    .pixel_ready_in           (pixel_ready_in),
    .pixel_start_of_frame_out (pixel_start_of_frame_out),
    .pixel_end_of_line_out    (pixel_end_of_line_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [15:0] pl(input logic [15:0] px);
    return PZ ? 16'h0 : px;
  endfunction

  // {eol, sof, hi, lo}
  function automatic logic [33:0] ob(input logic e, input logic s,
                                     input logic [15:0] hi, input logic [15:0] lo);
    return {e, s, hi, lo};
  endfunction

  // Record every output transfer seen by the next rising edge.
  always @(negedge clk) begin
    #2;
    if (pixel_valid_out && pixel_ready_in && clken)
      gotq.push_back({pixel_end_of_line_out, pixel_start_of_frame_out, pixel_pad_out});
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [31:0] d, input logic s, input logic e);
    int   n = 0;
    logic r = 1'b0;
    pixel_in = d; pixel_start_of_frame_in = s; pixel_end_of_line_in = e;
    pixel_valid_in = 1'b1;
    do begin
      #1 r = pixel_ready_out;
      @(negedge clk);
      n++;
    end while (!r && n < 50);
    if (!r) chk("accept_timeout", {63'd0, r}, 64'd1);
    pixel_valid_in = 1'b0; pixel_start_of_frame_in = 1'b0; pixel_end_of_line_in = 1'b0;
  endtask

  task automatic idle(input int n);
    pixel_valid_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic cmp_seq(input string tag, input logic [33:0] exp[$]);
    chk({tag, "_len"}, 64'(gotq.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < gotq.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), 64'(gotq[i]), 64'(exp[i]));
  endtask

  initial begin
    sclr = 1'b1; clken = 1'b1; pixel_in = '0; pixel_valid_in = 1'b0;
    pixel_end_of_line_in = 1'b0; pixel_start_of_frame_in = 1'b0; pixel_ready_in = 1'b1;
    exp1 = '{ob(0,1,16'h1,pl(16'h1)), ob(0,0,16'h3,16'h2), ob(0,0,16'h5,16'h4),
             ob(0,0,16'h7,16'h6), ob(1,0,pl(16'h8),16'h8)};
    repeat (3) @(negedge clk);
    sclr = 1'b0;
    #1;
    chk("rst_valid", 64'(pixel_valid_out), 64'd0);
    chk("rst_data",  64'(pixel_pad_out), 64'd0);
    chk("rst_sof",   64'(pixel_start_of_frame_out), 64'd0);
    chk("rst_eol",   64'(pixel_end_of_line_out), 64'd0);
    chk("rst_ready", 64'(pixel_ready_out), 64'd1);
    @(negedge clk);

    // Continuous 4-beat line; one input bubble for the tail.
    gotq.delete();
    send(32'h0002_0001, 1, 0);
    send(32'h0004_0003, 0, 0);
    send(32'h0006_0005, 0, 0);
    send(32'h0008_0007, 0, 1);
    #1 chk("tail_ready_low", 64'(pixel_ready_out), 64'd0);
    @(negedge clk);
    #1 chk("after_tail_ready", 64'(pixel_ready_out), 64'd1);
    idle(3);
    cmp_seq("line4", exp1);

    // Downstream stall of 3 cycles mid-line.
    gotq.delete();
    send(32'h0002_0001, 1, 0);
    send(32'h0004_0003, 0, 0);
    pixel_ready_in = 1'b0;
    pixel_in = 32'h0006_0005; pixel_valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall_ready%0d", i), 64'(pixel_ready_out), 64'd0);
      chk($sformatf("stall_valid%0d", i), 64'(pixel_valid_out), 64'd1);
      chk($sformatf("stall_data%0d", i),  64'(pixel_pad_out), 64'h0003_0002);
      @(negedge clk);
    end
    pixel_ready_in = 1'b1;
    send(32'h0006_0005, 0, 0);
    send(32'h0008_0007, 0, 1);
    idle(4);
    cmp_seq("stall", exp1);

    // Single-beat line with sof and eol.
    gotq.delete();
    send(32'hBBBB_AAAA, 1, 1);
    idle(4);
    expq = '{ob(0,1,16'hAAAA,pl(16'hAAAA)), ob(1,0,pl(16'hBBBB),16'hBBBB)};
    cmp_seq("single", expq);

    // Clear after beat 2, then a fresh 2-beat line.
    gotq.delete();
    send(32'h0002_0001, 1, 0);
    send(32'h0004_0003, 0, 0);
    pixel_ready_in = 1'b0; sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0; pixel_ready_in = 1'b1;
    #1;
    chk("sclr_valid", 64'(pixel_valid_out), 64'd0);
    chk("sclr_data",  64'(pixel_pad_out), 64'd0);
    chk("sclr_flags", 64'({pixel_start_of_frame_out, pixel_end_of_line_out}), 64'd0);
    chk("sclr_ready", 64'(pixel_ready_out), 64'd1);
    @(negedge clk);
    send(32'h0012_0011, 1, 0);
    send(32'h0014_0013, 0, 1);
    idle(4);
    expq = '{ob(0,1,16'h1,pl(16'h1)), ob(0,1,16'h11,pl(16'h11)),
             ob(0,0,16'h13,16'h12), ob(1,0,pl(16'h14),16'h14)};
    cmp_seq("sclr", expq);

    // clken toggling every cycle: same stream, frozen on disabled cycles.
    gotq.delete();
    tog_done = 1'b0;
    fork
      begin
        send(32'h0002_0001, 1, 0);
        send(32'h0004_0003, 0, 0);
        send(32'h0006_0005, 0, 0);
        send(32'h0008_0007, 0, 1);
        idle(8);
        tog_done = 1'b1;
      end
      begin
        while (!tog_done) begin
          logic [34:0] snap;
          clken = 1'b0;
          #2;
          snap = {pixel_valid_out, pixel_end_of_line_out, pixel_start_of_frame_out, pixel_pad_out};
          chk("clken_ready", 64'(pixel_ready_out), 64'd0);
          @(negedge clk);
          chk("clken_frozen", 64'({pixel_valid_out, pixel_end_of_line_out,
                                   pixel_start_of_frame_out, pixel_pad_out}), 64'(snap));
          clken = 1'b1;
          @(negedge clk);
        end
      end
    join
    clken = 1'b1;
    idle(2);
    cmp_seq("clken", exp1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
